threewire_responder: RTL and testbench
======================================

THREEWIRE_RESPONDER -- requirements
Module: threewire_responder

Interface
REQ-001 The block SHALL expose parameter ADDR_BITS, default 9, address field width.
REQ-002 The block SHALL expose parameter DATA_BITS, default 16, data field width.
REQ-003 The block SHALL expose parameter SYNC_STAGES, default 2, synchronizer depth for bus inputs.
REQ-004 The block SHALL have port in_clk  input  1  system clock.
REQ-005 The block SHALL have port in_rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_tw_clock  input  1  bus clock from initiator.
REQ-007 The block SHALL have port in_tw_cs  input  1  chip select, active-low.
REQ-008 The block SHALL have port io_tw_data  inout  1  bidirectional serial data.
REQ-009 The block SHALL have port out_addr  output  ADDR_BITS  captured register address.
REQ-010 The block SHALL have port out_wr_data  output  DATA_BITS  captured write data.
REQ-011 The block SHALL have port out_wr_strobe  output  1  one-cycle write commit pulse.
REQ-012 The block SHALL have port out_rd_req  output  1  one-cycle read fetch pulse.
REQ-013 The block SHALL have port in_rd_data  input  DATA_BITS  register read value.
REQ-014 The block SHALL have port in_rd_valid  input  1  in_rd_data valid, single-cycle.
REQ-015 The block SHALL have port out_busy  output  1  frame in progress.
REQ-016 The block SHALL have port out_frame_err  output  1  one-cycle error pulse.

Function
REQ-017 The block SHALL pass in_tw_clock, in_tw_cs, and io_tw_data through SYNC_STAGES flip-flops; edge detection SHALL use the synchronized values only; in_clk SHALL be at least 8x the bus clock.
REQ-018 The block SHALL sample io_tw_data on rising in_tw_clock edges and SHALL change its driven bit on falling edges.
REQ-019 Frame SHALL be: 1 r_w bit (1=write, 0=read), ADDR_BITS address bits MSB first, then either DATA_BITS write bits MSB first or a turnaround plus DATA_BITS read bits MSB first.
REQ-020 FSM states SHALL be IDLE, RW, ADDR, WDATA, TURN, RDATA, DONE; IDLE->RW on in_tw_cs falling.
REQ-021 The block SHALL move RW->ADDR on first rising edge, latching r_w, and ADDR->WDATA or ADDR->TURN after the ADDR_BITS-th rising edge.
REQ-022 The block SHALL update out_addr in the cycle after the last address bit is sampled; in the read case it SHALL pulse out_rd_req in that same cycle.
REQ-023 The block SHALL move WDATA->DONE after the DATA_BITS-th rising edge and SHALL pulse out_wr_strobe one cycle later, with out_wr_data and out_addr stable.
REQ-024 In TURN, io_tw_data SHALL stay hi-Z through the first falling edge after the last address sample; on the second falling edge the block SHALL drive bit DATA_BITS-1 and enter RDATA.
REQ-025 The block SHALL latch in_rd_data on in_rd_valid while in TURN; if no in_rd_valid arrives before the drive edge, it SHALL send all zeros and pulse out_frame_err.
REQ-026 RDATA SHALL shift one bit per falling edge; after bit 0's falling-edge hold, the next falling edge SHALL release to hi-Z and enter DONE.
REQ-027 DONE SHALL ignore further bus clocks and SHALL return to IDLE on in_tw_cs rising.
REQ-028 An in_tw_cs rise in any state other than IDLE or DONE SHALL abort the frame: release the bus, issue no strobe, pulse out_frame_err, return to IDLE.
REQ-029 io_tw_data SHALL be hi-Z whenever synchronized in_tw_cs is high or the state is not RDATA.
REQ-030 out_busy SHALL be 1 in every state except IDLE.
REQ-031 in_rd_valid outside TURN SHALL be ignored.

Reset
REQ-032 On in_rst the state SHALL be IDLE, io_tw_data hi-Z, all outputs 0, synchronizers 1 for in_tw_cs and 0 otherwise, immediately and mid-frame.

Structure
REQ-033 State encoding and the ADDR_BITS/DATA_BITS defaults SHALL live in a shared threewire package used by both initiator and responder.
REQ-034 The synchronizer-plus-edge-detector SHALL be one sub-module, threewire_sync_edge, instantiated per bus input.

Verification
REQ-035 Write r_w=1, addr 0x1A5, data 0xBEEF -> exactly one out_wr_strobe, out_addr=0x1A5, out_wr_data=0xBEEF.
REQ-036 Read addr 0x003, in_rd_valid with 0x1234 two in_clk cycles after out_rd_req -> bus carries 0x1234 MSB first; no out_frame_err.
REQ-037 Read with in_rd_valid withheld -> bus carries 0x0000; one out_frame_err pulse.
REQ-038 in_tw_cs rises after 5 address bits -> no strobe, one out_frame_err pulse, bus hi-Z, state IDLE.
REQ-039 in_rst asserted during RDATA bit 7 -> bus hi-Z immediately; next frame a clean write of 0x0001 to 0x000.
REQ-040 3 extra bus clocks after a write frame before in_tw_cs rises -> single strobe only, no error.

Source files
------------

// File: rtl/threewire_pkg.sv
// Shared definitions for the three-wire serial bus (initiator and responder).
// Holds the default field widths and the frame state encoding so both ends
// of the link agree on them.
package threewire_pkg;

  localparam int TW_ADDR_BITS = 9;
  localparam int TW_DATA_BITS = 16;

  typedef enum logic [2:0] {
    TW_IDLE,
    TW_RW,
    TW_ADDR,
    TW_WDATA,
    TW_TURN,
    TW_RDATA,
    TW_DONE
  } tw_state_t;

endpackage

// File: rtl/threewire_sync_edge.sv
// Multi-stage synchronizer with edge detection for one asynchronous bus input.
// Ports:
//   in_clk    system clock
//   in_rst    asynchronous active-high reset; flops load RESET_VAL
//   in_async  raw asynchronous input
//   out_sync  synchronized level
//   out_rise  one-cycle pulse on a synchronized 0->1 transition
//   out_fall  one-cycle pulse on a synchronized 1->0 transition
module threewire_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_async,
  output logic out_sync,
  output logic out_rise,
  output logic out_fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The cast drops the oldest stage, which keeps the shift legal for STAGES == 1.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, in_async});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign out_sync = sync_q[STAGES-1];
  assign out_rise = out_sync & ~prev_q;
  assign out_fall = ~out_sync & prev_q;

endmodule

// File: rtl/threewire_responder.sv
// Three-wire serial bus responder (target side).
// A frame is: r_w bit (1 = write), ADDR_BITS address bits MSB first, then
// either DATA_BITS write bits MSB first, or a turnaround and DATA_BITS read
// bits MSB first driven by this block. Bus inputs are oversampled on in_clk.
// Ports:
//   in_clk, in_rst   system clock, asynchronous active-high reset
//   in_tw_clock      bus clock from initiator (sampled rising, driven falling)
//   in_tw_cs         active-low chip select
//   io_tw_data       bidirectional serial data, driven only while sending read data
//   out_addr         captured register address
//   out_wr_data      captured write data
//   out_wr_strobe    one-cycle write commit pulse
//   out_rd_req       one-cycle read fetch pulse
//   in_rd_data       register read value, qualified by in_rd_valid
//   in_rd_valid      single-cycle valid for in_rd_data
//   out_busy         frame in progress
//   out_frame_err    one-cycle pulse on abort or missing read data
module threewire_responder
  import threewire_pkg::*;
#(
  parameter int ADDR_BITS   = TW_ADDR_BITS,
  parameter int DATA_BITS   = TW_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  wire                  io_tw_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_wr_data,
  output logic                 out_wr_strobe,
  output logic                 out_rd_req,
  input  logic [DATA_BITS-1:0] in_rd_data,
  input  logic                 in_rd_valid,
  output logic                 out_busy,
  output logic                 out_frame_err
);

  localparam int CNT_MAX = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  tw_state_t state_q, state_d;

  logic clk_sync, clk_rise, clk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic data_sync, data_rise, data_fall;

  logic                 rw_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_BITS-2:0] addr_sh_q;
  logic [DATA_BITS-2:0] wdata_sh_q;
  logic [DATA_BITS-1:0] rd_buf_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 rd_have_q;
  logic                 turn_fall_q;
  logic                 wr_pending_q;

  logic abort, addr_last, wdata_last, turn_drive, rdata_end;

  threewire_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_tw_clock),
    .out_sync (clk_sync),
    .out_rise (clk_rise),
    .out_fall (clk_fall)
  );

  threewire_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_tw_cs),
    .out_sync (cs_sync),
    .out_rise (cs_rise),
    .out_fall (cs_fall)
  );

  threewire_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (io_tw_data),
    .out_sync (data_sync),
    .out_rise (data_rise),
    .out_fall (data_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, clk_sync, data_rise, data_fall};

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= TW_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    abort      = 1'b0;
    addr_last  = 1'b0;
    wdata_last = 1'b0;
    turn_drive = 1'b0;
    rdata_end  = 1'b0;
    unique case (state_q)
      TW_IDLE: begin
        if (cs_fall) state_d = TW_RW;
      end
      TW_RW: begin
        if (cs_rise)       abort   = 1'b1;
        else if (clk_rise) state_d = TW_ADDR;
      end
      TW_ADDR: begin
        if (cs_rise) abort = 1'b1;
        else if (clk_rise && cnt_q == ADDR_LAST) begin
          addr_last = 1'b1;
          state_d   = rw_q ? TW_WDATA : TW_TURN;
        end
      end
      TW_WDATA: begin
        if (cs_rise) abort = 1'b1;
        else if (clk_rise && cnt_q == DATA_LAST) begin
          wdata_last = 1'b1;
          state_d    = TW_DONE;
        end
      end
      TW_TURN: begin
        // First falling edge is the turnaround slot; the second starts the MSB.
        if (cs_rise) abort = 1'b1;
        else if (clk_fall && turn_fall_q) begin
          turn_drive = 1'b1;
          state_d    = TW_RDATA;
        end
      end
      TW_RDATA: begin
        if (cs_rise) abort = 1'b1;
        else if (clk_fall && cnt_q == DATA_LAST) begin
          rdata_end = 1'b1;
          state_d   = TW_DONE;
        end
      end
      TW_DONE: begin
        if (cs_rise) state_d = TW_IDLE;
      end
      default: state_d = TW_IDLE;
    endcase
    if (abort) state_d = TW_IDLE;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rw_q          <= 1'b0;
      cnt_q         <= '0;
      addr_sh_q     <= '0;
      wdata_sh_q    <= '0;
      rd_buf_q      <= '0;
      tx_sh_q       <= '0;
      rd_have_q     <= 1'b0;
      turn_fall_q   <= 1'b0;
      wr_pending_q  <= 1'b0;
      out_addr      <= '0;
      out_wr_data   <= '0;
      out_wr_strobe <= 1'b0;
      out_rd_req    <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      out_wr_strobe <= wr_pending_q;
      wr_pending_q  <= 1'b0;
      out_rd_req    <= 1'b0;
      out_frame_err <= abort;

      if (state_q == TW_RW && state_d == TW_ADDR) begin
        rw_q  <= data_sync;
        cnt_q <= '0;
      end

      if (state_q == TW_ADDR && clk_rise && !abort) begin
        addr_sh_q <= (ADDR_BITS-1)'({addr_sh_q, data_sync});
        cnt_q     <= cnt_q + 1'b1;
      end

      if (addr_last) begin
        out_addr    <= {addr_sh_q, data_sync};
        out_rd_req  <= ~rw_q;
        cnt_q       <= '0;
        turn_fall_q <= 1'b0;
        rd_have_q   <= 1'b0;
      end

      if (state_q == TW_WDATA && clk_rise && !abort) begin
        wdata_sh_q <= (DATA_BITS-1)'({wdata_sh_q, data_sync});
        cnt_q      <= cnt_q + 1'b1;
      end

      if (wdata_last) begin
        out_wr_data  <= {wdata_sh_q, data_sync};
        wr_pending_q <= 1'b1;
      end

      if (state_q == TW_TURN) begin
        if (in_rd_valid) begin
          rd_buf_q  <= in_rd_data;
          rd_have_q <= 1'b1;
        end
        if (clk_fall && !abort) turn_fall_q <= 1'b1;
      end

      // Read data landing on the drive cycle itself still counts as on time.
      if (turn_drive) begin
        if (in_rd_valid)    tx_sh_q <= in_rd_data;
        else if (rd_have_q) tx_sh_q <= rd_buf_q;
        else                tx_sh_q <= '0;
        out_frame_err <= ~(in_rd_valid | rd_have_q);
        cnt_q         <= '0;
      end

      if (state_q == TW_RDATA && clk_fall && !abort && !rdata_end) begin
        tx_sh_q <= {tx_sh_q[DATA_BITS-2:0], 1'b0};
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign out_busy   = (state_q != TW_IDLE);
  assign io_tw_data = (state_q == TW_RDATA && !cs_sync) ? tx_sh_q[DATA_BITS-1] : 1'bz;

endmodule

// File: tb/tb_threewire_responder.sv
module tb_threewire_responder;

  localparam int AB   = 9;
  localparam int DB   = 16;
  localparam int HALF = 8;

  logic          in_clk   = 1'b0;
  logic          in_rst   = 1'b1;
  logic          tw_clock = 1'b0;
  logic          tw_cs    = 1'b1;
  logic          drv_en   = 1'b0;
  logic          drv_val  = 1'b0;
  logic [AB-1:0] out_addr;
  logic [DB-1:0] out_wr_data;
  logic          out_wr_strobe;
  logic          out_rd_req;
  logic [DB-1:0] in_rd_data;
  logic          in_rd_valid;
  logic          out_busy;
  logic          out_frame_err;

  wire tw_data;
  pullup (tw_data);
  assign tw_data = drv_en ? drv_val : 1'bz;

  threewire_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_tw_clock   (tw_clock),
    .in_tw_cs      (tw_cs),
    .io_tw_data    (tw_data),
    .out_addr      (out_addr),
    .out_wr_data   (out_wr_data),
    .out_wr_strobe (out_wr_strobe),
    .out_rd_req    (out_rd_req),
    .in_rd_data    (in_rd_data),
    .in_rd_valid   (in_rd_valid),
    .out_busy      (out_busy),
    .out_frame_err (out_frame_err)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Register-file model: reads are served from it, intended writes update it.
  logic [DB-1:0] regs [0:(1<<AB)-1];

  // Pulse monitors
  int            strobe_cnt = 0;
  int            err_cnt    = 0;
  int            rdreq_cnt  = 0;
  logic [AB-1:0] cap_addr   = '0;
  logic [DB-1:0] cap_data   = '0;

  always @(negedge in_clk) begin
    if (out_wr_strobe === 1'b1) begin
      strobe_cnt++;
      cap_addr = out_addr;
      cap_data = out_wr_data;
    end
    if (out_frame_err === 1'b1) err_cnt++;
    if (out_rd_req === 1'b1) rdreq_cnt++;
  end

  // Register-side responder for read fetches, plus stray valid pulses on request.
  logic rd_respond = 1'b1;
  int   rd_delay   = 2;
  int   stray_req  = 0;
  int   stray_done = 0;

  initial begin
    in_rd_valid = 1'b0;
    in_rd_data  = '0;
    forever begin
      @(negedge in_clk);
      if (out_rd_req === 1'b1 && rd_respond) begin
        logic [DB-1:0] v;
        v = regs[out_addr];
        repeat (rd_delay) @(posedge in_clk);
        #1;
        in_rd_valid = 1'b1;
        in_rd_data  = v;
        @(posedge in_clk);
        #1;
        in_rd_valid = 1'b0;
        in_rd_data  = DB'($urandom);
      end else if (stray_req != stray_done) begin
        stray_done++;
        @(posedge in_clk);
        #1;
        in_rd_valid = 1'b1;
        in_rd_data  = '1;
        @(posedge in_clk);
        #1;
        in_rd_valid = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bus-level helpers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic bus_bit(input logic b);
    drv_en  = 1'b1;
    drv_val = b;
    wait_clk(HALF);
    tw_clock = 1'b1;
    wait_clk(HALF);
    tw_clock = 1'b0;
  endtask

  task automatic frame_start();
    tw_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    drv_en = 1'b0;
    tw_cs  = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send_header(input logic rw, input logic [AB-1:0] a);
    bus_bit(rw);
    for (int i = AB - 1; i >= 0; i--) bus_bit(a[i]);
  endtask

  task automatic turnaround();
    drv_en = 1'b0;
    wait_clk(HALF);
    tw_clock = 1'b1;
    wait_clk(HALF);
    tw_clock = 1'b0;
  endtask

  task automatic read_bits(input int n, inout logic [DB-1:0] w);
    for (int i = 0; i < n; i++) begin
      wait_clk(HALF);
      w[DB-1-i] = tw_data;
      tw_clock = 1'b1;
      wait_clk(HALF);
      tw_clock = 1'b0;
    end
  endtask

  task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input int extra);
    frame_start();
    send_header(1'b1, a);
    for (int i = DB - 1; i >= 0; i--) bus_bit(d[i]);
    for (int i = 0; i < extra; i++) bus_bit(1'($urandom));
    frame_end();
  endtask

  task automatic do_read(input logic [AB-1:0] a, output logic [DB-1:0] w);
    w = 'x;
    frame_start();
    send_header(1'b0, a);
    turnaround();
    read_bits(DB, w);
    frame_end();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_rst = 1'b1;
    wait_clk(3);
    if (out_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", out_busy); n_bad++; end
    n_cmp++;
    if (out_addr !== '0) begin $display("FAIL reset_addr: got %h want 0", out_addr); n_bad++; end
    n_cmp++;
    if (out_wr_data !== '0) begin $display("FAIL reset_wdata: got %h want 0", out_wr_data); n_bad++; end
    n_cmp++;
    if ({out_wr_strobe, out_rd_req, out_frame_err} !== 3'b000) begin
      $display("FAIL reset_pulses: got %b want 000", {out_wr_strobe, out_rd_req, out_frame_err}); n_bad++;
    end
    n_cmp++;
    if (tw_data !== 1'b1) begin $display("FAIL reset_bus_released: got %b want pulled 1", tw_data); n_bad++; end
    n_cmp++;
    in_rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write_basic();
    int s0, e0, r0;
    logic [AB-1:0] a;
    logic [DB-1:0] d;
    a = 9'h1A5; d = 16'hBEEF;
    s0 = strobe_cnt; e0 = err_cnt; r0 = rdreq_cnt;
    frame_start();
    send_header(1'b1, a);
    if (out_busy !== 1'b1) begin $display("FAIL write_busy_mid: got %b want 1", out_busy); n_bad++; end
    n_cmp++;
    if (out_addr !== a) begin $display("FAIL write_addr_early: got %h want %h", out_addr, a); n_bad++; end
    n_cmp++;
    for (int i = DB - 1; i >= 0; i--) bus_bit(d[i]);
    frame_end();
    regs[a] = d;
    if (strobe_cnt - s0 !== 1) begin $display("FAIL write_strobes: got %0d want 1", strobe_cnt - s0); n_bad++; end
    n_cmp++;
    if (cap_addr !== a) begin $display("FAIL write_addr: got %h want %h", cap_addr, a); n_bad++; end
    n_cmp++;
    if (cap_data !== d) begin $display("FAIL write_data: got %h want %h", cap_data, d); n_bad++; end
    n_cmp++;
    if (err_cnt - e0 !== 0 || rdreq_cnt - r0 !== 0) begin
      $display("FAIL write_no_err_rdreq: got err %0d rdreq %0d want 0 0", err_cnt - e0, rdreq_cnt - r0); n_bad++;
    end
    n_cmp++;
    if (out_busy !== 1'b0) begin $display("FAIL write_busy_end: got %b want 0", out_busy); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_read_valid();
    int e0, r0;
    logic [DB-1:0] w;
    regs[3] = 16'h1234;
    rd_respond = 1'b1; rd_delay = 2;
    e0 = err_cnt; r0 = rdreq_cnt;
    do_read(9'h003, w);
    if (w !== 16'h1234) begin $display("FAIL read_word: got %h want 1234", w); n_bad++; end
    n_cmp++;
    if (err_cnt - e0 !== 0) begin $display("FAIL read_err: got %0d want 0", err_cnt - e0); n_bad++; end
    n_cmp++;
    if (rdreq_cnt - r0 !== 1) begin $display("FAIL read_rdreq: got %0d want 1", rdreq_cnt - r0); n_bad++; end
    n_cmp++;
    if (out_addr !== 9'h003) begin $display("FAIL read_addr: got %h want 003", out_addr); n_bad++; end
    n_cmp++;
    if (tw_data !== 1'b1) begin $display("FAIL read_bus_released: got %b want pulled 1", tw_data); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_read_withheld();
    int e0;
    logic [DB-1:0] w;
    logic [AB-1:0] a;
    a = AB'($urandom);
    rd_respond = 1'b0;
    e0 = err_cnt;
    w = 'x;
    frame_start();
    stray_req++;
    send_header(1'b0, a);
    turnaround();
    read_bits(DB, w);
    frame_end();
    rd_respond = 1'b1;
    if (w !== 16'h0000) begin $display("FAIL withheld_word: got %h want 0000", w); n_bad++; end
    n_cmp++;
    if (err_cnt - e0 !== 1) begin $display("FAIL withheld_err: got %0d want 1", err_cnt - e0); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_abort();
    int s0, e0;
    s0 = strobe_cnt; e0 = err_cnt;
    frame_start();
    bus_bit(1'b1);
    for (int i = 0; i < 5; i++) bus_bit(1'($urandom));
    frame_end();
    if (strobe_cnt - s0 !== 0) begin $display("FAIL abort_strobe: got %0d want 0", strobe_cnt - s0); n_bad++; end
    n_cmp++;
    if (err_cnt - e0 !== 1) begin $display("FAIL abort_err: got %0d want 1", err_cnt - e0); n_bad++; end
    n_cmp++;
    if (out_busy !== 1'b0) begin $display("FAIL abort_idle: got busy %b want 0", out_busy); n_bad++; end
    n_cmp++;
    if (tw_data !== 1'b1) begin $display("FAIL abort_bus: got %b want pulled 1", tw_data); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid_rdata();
    int s0, e0;
    logic [AB-1:0] a;
    logic [DB-1:0] w, exp_w;
    a = AB'($urandom);
    regs[a] = DB'($urandom) & 16'hFF7F;
    exp_w = regs[a];
    rd_respond = 1'b1; rd_delay = 2;
    w = '0;
    frame_start();
    send_header(1'b0, a);
    turnaround();
    read_bits(8, w);
    wait_clk(4);
    if (w[DB-1:8] !== exp_w[DB-1:8]) begin $display("FAIL midrst_upper: got %h want %h", w[DB-1:8], exp_w[DB-1:8]); n_bad++; end
    n_cmp++;
    if (tw_data !== 1'b0) begin $display("FAIL midrst_bit7_driven: got %b want 0", tw_data); n_bad++; end
    n_cmp++;
    in_rst = 1'b1;
    #1;
    if (tw_data !== 1'b1) begin $display("FAIL midrst_bus_hiz: got %b want pulled 1", tw_data); n_bad++; end
    n_cmp++;
    if (out_busy !== 1'b0) begin $display("FAIL midrst_busy: got %b want 0", out_busy); n_bad++; end
    n_cmp++;
    tw_cs = 1'b1; tw_clock = 1'b0; drv_en = 1'b0;
    wait_clk(4);
    in_rst = 1'b0;
    wait_clk(4);
    s0 = strobe_cnt; e0 = err_cnt;
    do_write(9'h000, 16'h0001, 0);
    regs[0] = 16'h0001;
    if (strobe_cnt - s0 !== 1) begin $display("FAIL postrst_strobes: got %0d want 1", strobe_cnt - s0); n_bad++; end
    n_cmp++;
    if (cap_addr !== 9'h000 || cap_data !== 16'h0001) begin
      $display("FAIL postrst_write: got %h/%h want 000/0001", cap_addr, cap_data); n_bad++;
    end
    n_cmp++;
    if (err_cnt - e0 !== 0) begin $display("FAIL postrst_err: got %0d want 0", err_cnt - e0); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_extra_clocks();
    int s0, e0;
    logic [AB-1:0] a;
    logic [DB-1:0] d;
    a = AB'($urandom); d = DB'($urandom);
    s0 = strobe_cnt; e0 = err_cnt;
    do_write(a, d, 3);
    regs[a] = d;
    if (strobe_cnt - s0 !== 1) begin $display("FAIL extra_strobes: got %0d want 1", strobe_cnt - s0); n_bad++; end
    n_cmp++;
    if (err_cnt - e0 !== 0) begin $display("FAIL extra_err: got %0d want 0", err_cnt - e0); n_bad++; end
    n_cmp++;
    if (cap_data !== d) begin $display("FAIL extra_data: got %h want %h", cap_data, d); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 10; n++) begin
      int s0, e0;
      logic rw;
      logic [AB-1:0] a;
      logic [DB-1:0] d, w;
      rw = 1'($urandom);
      a  = AB'($urandom);
      d  = DB'($urandom);
      rd_respond = ($urandom_range(0, 3) != 0);
      rd_delay   = int'($urandom_range(1, 6));
      s0 = strobe_cnt; e0 = err_cnt;
      if (rw) begin
        do_write(a, d, 0);
        regs[a] = d;
        if (strobe_cnt - s0 !== 1 || cap_addr !== a || cap_data !== d) begin
          $display("FAIL rand_write[%0d]: got n=%0d %h/%h want n=1 %h/%h", n, strobe_cnt - s0, cap_addr, cap_data, a, d); n_bad++;
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin $display("FAIL rand_write_err[%0d]: got %0d want 0", n, err_cnt - e0); n_bad++; end
        n_cmp++;
      end else begin
        logic [DB-1:0] exp_w;
        exp_w = rd_respond ? regs[a] : '0;
        do_read(a, w);
        if (w !== exp_w) begin $display("FAIL rand_read[%0d]: got %h want %h", n, w, exp_w); n_bad++; end
        n_cmp++;
        if (err_cnt - e0 !== (rd_respond ? 0 : 1)) begin
          $display("FAIL rand_read_err[%0d]: got %0d want %0d", n, err_cnt - e0, rd_respond ? 0 : 1); n_bad++;
        end
        n_cmp++;
        if (strobe_cnt - s0 !== 0) begin $display("FAIL rand_read_strobe[%0d]: got %0d want 0", n, strobe_cnt - s0); n_bad++; end
        n_cmp++;
      end
    end
    rd_respond = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AB); i++) regs[i] = DB'($urandom);
    test_reset();
    test_write_basic();
    test_read_valid();
    test_read_withheld();
    test_abort();
    test_reset_mid_rdata();
    test_extra_clocks();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
